// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks.
//   WEIGHT_W_DEFAULT : default weight word width
//   ser_state_t      : weight serializer shifter FSM states
//   bit_cnt_width()  : width of a counter that indexes the bits of a word
package nn_pkg;

  localparam int unsigned WEIGHT_W_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Keep at least one bit so a 1-bit word still gets a legal counter.
  function automatic int unsigned bit_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/weight_serializer_if.sv
// Handshake bundle for the weight serializer.
//   master : producer/consumer side (drives weight_in, weight_valid, bit_ready)
//   slave  : serializer side (drives weight_ready and the serial bit stream)
interface weight_serializer_if #(
  parameter int unsigned WEIGHT_W = nn_pkg::WEIGHT_W_DEFAULT
);

  logic [WEIGHT_W-1:0] weight_in;
  logic                weight_valid;
  logic                weight_ready;
  logic                bit_ready;
  logic                Weight_bit;
  logic                bit_valid;
  logic                word_first;
  logic                word_last;
  logic                busy;

  modport master (
    output weight_in, weight_valid, bit_ready,
    input  weight_ready, Weight_bit, bit_valid, word_first, word_last, busy
  );

  modport slave (
    input  weight_in, weight_valid, bit_ready,
    output weight_ready, Weight_bit, bit_valid, word_first, word_last, busy
  );

endinterface

// File: rtl/weight_fifo.sv
// Synchronous FIFO used to buffer words ahead of a serializer.
//   clk, reset : clock and asynchronous active-high reset
//   push/wdata : write request and data (ignored while full)
//   pop/rdata  : read request (ignored while empty); rdata shows the head
//   full/empty : occupancy flags
//   count      : number of stored words
module weight_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rptr_q];
  // No bypass: a full FIFO refuses a push even if a pop happens this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/weight_serializer.sv
// Bit-serial weight source: buffers parallel weight words and shifts them out
// one bit per accepted clock, back-to-back while words are available.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : weight_in/weight_valid/weight_ready word handshake in,
//                Weight_bit/bit_valid/bit_ready serial stream out, with
//                word_first/word_last framing and busy status
module weight_serializer
  import nn_pkg::*;
#(
  parameter int unsigned WEIGHT_W   = WEIGHT_W_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  weight_serializer_if.slave bus
);

  localparam int unsigned CntW  = bit_cnt_width(WEIGHT_W);
  localparam int unsigned FCntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WEIGHT_W - 1);

  ser_state_t          state_q;
  logic [WEIGHT_W-1:0] sreg_q, sreg_shift;
  logic [CntW-1:0]     bit_cnt_q;

  logic [WEIGHT_W-1:0] fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [FCntW-1:0]    fifo_count;

  logic at_last;
  assign at_last = (state_q == SHIFT) && (bit_cnt_q == LastCnt);

  // Pop when idle, or when the last bit is consumed so the next word follows
  // without a bubble.
  assign fifo_pop = !fifo_empty && ((state_q == IDLE) || (at_last && bus.bit_ready));

  weight_fifo #(
    .WIDTH (WEIGHT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.weight_valid),
    .wdata (bus.weight_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    sreg_shift = sreg_q;
    if (MSB_FIRST) sreg_shift = sreg_q << 1;
    else           sreg_shift = sreg_q >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            sreg_q    <= fifo_rdata;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.bit_ready) begin
            if (bit_cnt_q == LastCnt) begin
              bit_cnt_q <= '0;
              if (!fifo_empty) begin
                sreg_q <= fifo_rdata;
              end else begin
                // Clear so the idle output bit reads 0.
                sreg_q  <= '0;
                state_q <= IDLE;
              end
            end else begin
              sreg_q    <= sreg_shift;
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.weight_ready = !fifo_full;
  assign bus.Weight_bit   = MSB_FIRST ? sreg_q[WEIGHT_W-1] : sreg_q[0];
  assign bus.bit_valid    = (state_q == SHIFT);
  assign bus.word_first   = (state_q == SHIFT) && (bit_cnt_q == '0);
  assign bus.word_last    = at_last;
  assign bus.busy         = (state_q == SHIFT) || (fifo_count != '0);

endmodule

// File: tb/tb_weight_serializer.sv
// Directed self-checking bench for weight_serializer (MSB-first and LSB-first
// instances sharing clock and reset).
module tb_weight_serializer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  weight_serializer_if #(.WEIGHT_W(8)) bus1 ();
  weight_serializer_if #(.WEIGHT_W(8)) bus2 ();

  weight_serializer #(
    .WEIGHT_W   (8),
    .FIFO_DEPTH (2),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  weight_serializer #(
    .WEIGHT_W   (8),
    .FIFO_DEPTH (2),
    .MSB_FIRST  (1'b0)
  ) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check bit i of word w on bus1 (MSB first).
  task automatic check_bit1(input string tag, input logic [7:0] w, input int i);
    check($sformatf("%s_valid%0d", tag, i), 32'(bus1.bit_valid), 32'd1);
    check($sformatf("%s_bit%0d", tag, i), 32'(bus1.Weight_bit), 32'(w[7-i]));
    check($sformatf("%s_first%0d", tag, i), 32'(bus1.word_first), 32'(i == 0));
    check($sformatf("%s_last%0d", tag, i), 32'(bus1.word_last), 32'(i == 7));
  endtask

  task automatic expect_word1(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      check_bit1(tag, w, i);
      step();
    end
  endtask

  task automatic expect_idle1(input string tag);
    check({tag, "_valid"}, 32'(bus1.bit_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    check({tag, "_ready"}, 32'(bus1.weight_ready), 32'd1);
  endtask

  task automatic push1(input logic [7:0] w);
    bus1.weight_in    = w;
    bus1.weight_valid = 1'b1;
    step();
    bus1.weight_valid = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_bit"}, 32'(bus1.Weight_bit), 32'd0);
    check({tag, "_valid"}, 32'(bus1.bit_valid), 32'd0);
    check({tag, "_first"}, 32'(bus1.word_first), 32'd0);
    check({tag, "_last"}, 32'(bus1.word_last), 32'd0);
    check({tag, "_busy"}, 32'(bus1.busy), 32'd0);
    check({tag, "_ready"}, 32'(bus1.weight_ready), 32'd1);
  endtask

  logic [7:0] full_words [4];

  initial begin
    reset             = 1'b1;
    bus1.weight_in    = '0;
    bus1.weight_valid = 1'b0;
    bus1.bit_ready    = 1'b0;
    bus2.weight_in    = '0;
    bus2.weight_valid = 1'b0;
    bus2.bit_ready    = 1'b0;
    full_words[0] = 8'h11;
    full_words[1] = 8'h22;
    full_words[2] = 8'h33;
    full_words[3] = 8'h44;

    step();
    step();
    check_reset_outs("rst_hold");
    reset = 1'b0;
    step();
    check_reset_outs("rst_post");

    // Single word, 2-edge latency.
    bus1.bit_ready = 1'b1;
    push1(8'b0110_1001);
    check("single_lat_valid", 32'(bus1.bit_valid), 32'd0);
    check("single_lat_busy", 32'(bus1.busy), 32'd1);
    step();
    expect_word1("single", 8'b0110_1001);
    expect_idle1("single_end");

    // Back-to-back words with no bubble.
    bus1.weight_in    = 8'hA5;
    bus1.weight_valid = 1'b1;
    step();
    bus1.weight_in    = 8'h3C;
    step();
    bus1.weight_valid = 1'b0;
    expect_word1("b2b_a5", 8'hA5);
    expect_word1("b2b_3c", 8'h3C);
    expect_idle1("b2b_end");

    // Stall on bit index 3 of 0xF0 for three cycles.
    push1(8'hF0);
    step();
    for (int i = 0; i < 3; i++) begin
      check_bit1("stall_pre", 8'hF0, i);
      step();
    end
    bus1.bit_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_bit1("stall_hold", 8'hF0, 3);
      check($sformatf("stall_cnt%0d", s), 32'(dut.bit_cnt_q), 32'd3);
      step();
    end
    bus1.bit_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      check_bit1("stall_post", 8'hF0, i);
      step();
    end
    expect_idle1("stall_end");

    // Full: capacity is 2 FIFO words plus the shifter.
    bus1.bit_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus1.weight_in    = full_words[k];
      bus1.weight_valid = 1'b1;
      check($sformatf("full_ready%0d", k), 32'(bus1.weight_ready), 32'(k < 3));
      step();
    end
    bus1.weight_valid = 1'b0;
    check("full_ready_after", 32'(bus1.weight_ready), 32'd0);
    bus1.bit_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_ready_w1_%0d", i), 32'(bus1.weight_ready), 32'd0);
      check_bit1("full_w1", 8'h11, i);
      step();
    end
    check("full_ready_rise", 32'(bus1.weight_ready), 32'd1);
    expect_word1("full_w2", 8'h22);
    expect_word1("full_w3", 8'h33);
    expect_idle1("full_end");

    // Reset mid-word with two words queued.
    bus1.weight_in    = 8'hFF;
    bus1.weight_valid = 1'b1;
    step();
    bus1.weight_in = 8'h81;
    step();
    bus1.weight_in = 8'h7E;
    step();
    bus1.weight_valid = 1'b0;
    step();
    step();
    check_bit1("rmid_pre", 8'hFF, 3);
    check("rmid_pre_ready", 32'(bus1.weight_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("rmid_async");
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("rmid_quiet_valid%0d", c), 32'(bus1.bit_valid), 32'd0);
      check($sformatf("rmid_quiet_busy%0d", c), 32'(bus1.busy), 32'd0);
      step();
    end
    push1(8'h5A);
    step();
    expect_word1("rmid_new", 8'h5A);
    expect_idle1("rmid_end");

    // LSB-first instance.
    bus2.bit_ready = 1'b1;
    bus2.weight_in    = 8'h01;
    bus2.weight_valid = 1'b1;
    step();
    bus2.weight_in = 8'hB4;
    step();
    bus2.weight_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lsb01_valid%0d", i), 32'(bus2.bit_valid), 32'd1);
      check($sformatf("lsb01_bit%0d", i), 32'(bus2.Weight_bit), 32'(i == 0));
      check($sformatf("lsb01_first%0d", i), 32'(bus2.word_first), 32'(i == 0));
      check($sformatf("lsb01_last%0d", i), 32'(bus2.word_last), 32'(i == 7));
      step();
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] wb4;
      wb4 = 8'hB4;
      check($sformatf("lsbb4_bit%0d", i), 32'(bus2.Weight_bit), 32'(wb4[i]));
      step();
    end
    check("lsb_end_valid", 32'(bus2.bit_valid), 32'd0);
    check("lsb_end_busy", 32'(bus2.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
